// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the regfile write-side arbiter.
// Contents: register-address / data widths, the {rd,data} entry layout used
// by the mul/div result buffer, and the write-port source encoding.
package reg_wb_arbiter_pkg;

   localparam int REG_AW = 5;
   localparam int XLEN   = 32;
   localparam int NREG   = 1 << REG_AW;
   localparam int WB_W   = REG_AW + XLEN;

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   // One buffered mul/div result: destination register in the top bits.
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

   // Which requester owns the regfile write port this cycle.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PIPE = 2'd1,
      SRC_FIFO = 2'd2,
      SRC_CUT  = 2'd3
   } wb_src_e;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bus bundle around the write-side arbiter.
// Groups the pipeline writeback request, mul/div issue and result handshake,
// scoreboard query/answer, pipeline hold and the regfile write port.
// modport slave  : the arbiter view.
// modport master : the surrounding core (or bench) view.
interface reg_wb_arbiter_if;
   import reg_wb_arbiter_pkg::*;

   logic              pipe_wen;
   logic [REG_AW-1:0] pipe_rd;
   logic [XLEN-1:0]   pipe_wdata;
   logic              md_issue_valid;
   logic [REG_AW-1:0] md_issue_rd;
   logic              md_valid;
   logic              md_ready;
   logic [REG_AW-1:0] md_rd;
   logic [XLEN-1:0]   md_wdata;
   logic [REG_AW-1:0] q_rs1;
   logic [REG_AW-1:0] q_rs2;
   logic              busy1;
   logic              busy2;
   logic              pipe_hold;
   logic              WEn3;
   logic [REG_AW-1:0] A3;
   logic [XLEN-1:0]   WD3;

   modport slave (
      input  pipe_wen, pipe_rd, pipe_wdata, md_issue_valid, md_issue_rd,
      input  md_valid, md_rd, md_wdata, q_rs1, q_rs2,
      output md_ready, busy1, busy2, pipe_hold, WEn3, A3, WD3
   );

   modport master (
      output pipe_wen, pipe_rd, pipe_wdata, md_issue_valid, md_issue_rd,
      output md_valid, md_rd, md_wdata, q_rs1, q_rs2,
      input  md_ready, busy1, busy2, pipe_hold, WEn3, A3, WD3
   );

endinterface

// File: rtl/reg_wb_arbiter_chk.sv
// Simulation-only protocol checker for reg_wb_arbiter.
// Flags: pipeline WAW on a pending register, double issue to a pending
// register, mul/div result for a register not pending, and pipeline writeback
// while pipe_hold is high. A re-issue to a register whose previous mul/div
// result is being written in the same cycle is legitimate.
module reg_wb_arbiter_chk
   import reg_wb_arbiter_pkg::*;
(
   input logic              clk,
   input logic              rst,
   input logic              pipe_wen,
   input logic              pipe_act,
   input logic [REG_AW-1:0] pipe_rd,
   input logic              hold,
   input logic              issue_valid,
   input logic [REG_AW-1:0] issue_rd,
   input logic              md_valid,
   input logic [REG_AW-1:0] md_rd,
   input logic [NREG-1:0]   pending,
   input logic              clr,
   input logic [REG_AW-1:0] clr_rd
);

   // Protocol checks sampled on every active edge outside reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(pipe_act && pending[pipe_rd]))
            else $error("protocol: pipeline write to pending x%0d", pipe_rd);
         assert (!(issue_valid && (issue_rd != REG_ZERO) && pending[issue_rd]
                   && !(clr && (clr_rd == issue_rd))))
            else $error("protocol: issue to already pending x%0d", issue_rd);
         assert (!(md_valid && (md_rd != REG_ZERO) && !pending[md_rd]))
            else $error("protocol: result for non-pending x%0d", md_rd);
         assert (!(hold && pipe_wen))
            else $error("protocol: pipeline writeback during pipe_hold");
      end
   end

endmodule

// File: rtl/reg_wb_arbiter_wb_fifo.sv
// wb_fifo: synchronous FIFO buffering mul/div results ({rd,data} entries).
// Ports: clk, rst (sync, active-high), push/din, pop, full, empty, head
// (first-word-fall-through view of the oldest entry).
// DEPTH must be a power of two so pointers wrap naturally.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 37
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_r;
   logic [AW-1:0] rd_r;
   logic [AW:0]   cnt_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   // A push into a full FIFO is only legal when the head leaves the same cycle.
   assign push_ok_s = push && (!full || pop);
   assign pop_ok_s  = pop && !empty;
   assign full      = (cnt_r == FULL_CNT);
   assign empty     = (cnt_r == {(AW+1){1'b0}});
   assign head      = mem_r[rd_r];

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_r  <= {AW{1'b0}};
         rd_r  <= {AW{1'b0}};
         cnt_r <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
      end else begin
         if (push_ok_s) begin
            mem_r[wr_r] <= din;
            wr_r        <= wr_r + 1'b1;
         end
         if (pop_ok_s) begin
            rd_r <= rd_r + 1'b1;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_r <= cnt_r + 1'b1;
            2'b01:   cnt_r <= cnt_r - 1'b1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: sole driver of the regfile write port (WEn3/A3/WD3).
// Ports: clk, rst (sync, active-high), bus (reg_wb_arbiter_if.slave) carrying
//   pipeline writeback, mul/div issue + result handshake, scoreboard queries
//   (busy1/busy2), pipe_hold and the regfile write port.
// The pipeline has fixed priority; mul/div results are buffered in wb_fifo,
// cut through when the buffer is empty and the port is free. A starvation
// counter raises pipe_hold for one cycle so the buffer can drain.
module reg_wb_arbiter
   import reg_wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input logic             clk,
   input logic             rst,
   reg_wb_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic              pipe_act_s;
   logic              md_ready_s;
   logic              md_hs_s;
   logic              md_keep_s;
   logic              full_s;
   logic              empty_s;
   logic              push_s;
   logic              pop_s;
   logic              cut_s;
   logic              md_clr_s;
   logic              blocked_s;
   logic [REG_AW-1:0] md_clr_rd_s;
   logic [WB_W-1:0]   head_raw_s;
   wb_entry_t         head_s;
   wb_src_e           src_s;
   logic              wen_s;
   logic [REG_AW-1:0] a_s;
   logic [XLEN-1:0]   wd_s;
   logic [NREG-1:0]   pend_nxt_s;
   logic [NREG-1:0]   pending_r;
   logic              hold_r;
   logic [SW-1:0]     starve_r;
   logic [SW-1:0]     starve_inc_s;

   assign pipe_act_s   = bus.pipe_wen && (bus.pipe_rd != REG_ZERO);
   assign md_ready_s   = !rst && !full_s;
   assign md_hs_s      = bus.md_valid && md_ready_s;
   // Results to x0 are accepted but never reach the port, FIFO or scoreboard.
   assign md_keep_s    = md_hs_s && (bus.md_rd != REG_ZERO);
   assign head_s       = head_raw_s;
   assign pop_s        = (src_s == SRC_FIFO);
   assign cut_s        = (src_s == SRC_CUT);
   assign push_s       = md_keep_s && !cut_s;
   assign md_clr_s     = pop_s || cut_s;
   assign md_clr_rd_s  = pop_s ? head_s.rd : bus.md_rd;
   assign blocked_s    = !empty_s && (src_s == SRC_PIPE);
   assign starve_inc_s = starve_r + 1'b1;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (WB_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .din   ({bus.md_rd, bus.md_wdata}),
      .pop   (pop_s),
      .full  (full_s),
      .empty (empty_s),
      .head  (head_raw_s)
   );

   // Write-port owner: pipeline, then buffered head, then cut-through.
   // During pipe_hold the buffer wins even if the pipeline misbehaves.
   always_comb begin
      src_s = SRC_NONE;
      if (rst) begin
         src_s = SRC_NONE;
      end else if (pipe_act_s && !hold_r) begin
         src_s = SRC_PIPE;
      end else if (!empty_s) begin
         src_s = SRC_FIFO;
      end else if (md_keep_s) begin
         src_s = SRC_CUT;
      end else begin
         src_s = SRC_NONE;
      end
   end

   // Regfile write port mux; idle port drives zeros.
   always_comb begin
      wen_s = 1'b0;
      a_s   = REG_ZERO;
      wd_s  = 32'd0;
      case (src_s)
         SRC_PIPE: begin
            wen_s = 1'b1;
            a_s   = bus.pipe_rd;
            wd_s  = bus.pipe_wdata;
         end
         SRC_FIFO: begin
            wen_s = 1'b1;
            a_s   = head_s.rd;
            wd_s  = head_s.data;
         end
         SRC_CUT: begin
            wen_s = 1'b1;
            a_s   = bus.md_rd;
            wd_s  = bus.md_wdata;
         end
         default: begin
            wen_s = 1'b0;
            a_s   = REG_ZERO;
            wd_s  = 32'd0;
         end
      endcase
   end

   // Scoreboard next state: clear on md write, then set on issue (set wins).
   always_comb begin
      pend_nxt_s = pending_r;
      if (md_clr_s) begin
         pend_nxt_s[md_clr_rd_s] = 1'b0;
      end else begin
         pend_nxt_s[md_clr_rd_s] = pending_r[md_clr_rd_s];
      end
      if (bus.md_issue_valid && (bus.md_issue_rd != REG_ZERO)) begin
         pend_nxt_s[bus.md_issue_rd] = 1'b1;
      end else begin
         pend_nxt_s[bus.md_issue_rd] = pend_nxt_s[bus.md_issue_rd];
      end
      pend_nxt_s[0] = 1'b0;
   end

   // Scoreboard bits, starvation counter and one-cycle pipe_hold pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_r <= {NREG{1'b0}};
         hold_r    <= 1'b0;
         starve_r  <= {SW{1'b0}};
      end else begin
         pending_r <= pend_nxt_s;
         if (blocked_s && (starve_inc_s == STARVE_LIM)) begin
            hold_r   <= 1'b1;
            starve_r <= {SW{1'b0}};
         end else if (blocked_s) begin
            hold_r   <= 1'b0;
            starve_r <= starve_inc_s;
         end else begin
            hold_r   <= 1'b0;
            starve_r <= {SW{1'b0}};
         end
      end
   end

   assign bus.md_ready  = md_ready_s;
   assign bus.busy1     = !rst && pending_r[bus.q_rs1];
   assign bus.busy2     = !rst && pending_r[bus.q_rs2];
   assign bus.pipe_hold = hold_r;
   assign bus.WEn3      = wen_s;
   assign bus.A3        = a_s;
   assign bus.WD3       = wd_s;

   reg_wb_arbiter_chk u_chk (
      .clk         (clk),
      .rst         (rst),
      .pipe_wen    (bus.pipe_wen),
      .pipe_act    (pipe_act_s),
      .pipe_rd     (bus.pipe_rd),
      .hold        (hold_r),
      .issue_valid (bus.md_issue_valid),
      .issue_rd    (bus.md_issue_rd),
      .md_valid    (bus.md_valid),
      .md_rd       (bus.md_rd),
      .pending     (pending_r),
      .clr         (md_clr_s),
      .clr_rd      (md_clr_rd_s)
   );

endmodule
